// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU request sequencer: op codes, FSM states, default widths.
package alu_seq_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Ops the external ALU completes in one pass.
  function automatic logic is_single_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Request-side sequencer for an external combinational ALU: single-pass ops plus
// a 32-step shift-add MULTU built on the ALU adder and its carry-out.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_z,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_lo,
  output logic [XLEN-1:0] rsp_hi,
  output logic            rsp_zero,
  output logic            rsp_err
);

  logic [1:0]      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0] mcand, mcand_n;
  // Multiplier bit 0 is consumed at accept time, so only bits [XLEN-1:1] are kept.
  logic [XLEN-1:1] lo_q, lo_q_n;
  logic            req_ready_n, rsp_valid_n, rsp_zero_n, rsp_err_n;
  logic [3:0]      alu_op_n;
  logic [XLEN-1:0] alu_a_n, alu_b_n, rsp_lo_n, rsp_hi_n;
  logic [XLEN-1:0] mul_hi, mul_lo;

  // One shift-add step: {carry, sum} shifted right into the product; hi lives in alu_a.
  assign mul_hi = {alu_zero, alu_z[XLEN-1:1]};
  assign mul_lo = {alu_z[0], lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      lo_q      <= '0;
      req_ready <= 1'b1;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mcand     <= mcand_n;
      lo_q      <= lo_q_n;
      req_ready <= req_ready_n;
      alu_op    <= alu_op_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      rsp_valid <= rsp_valid_n;
      rsp_lo    <= rsp_lo_n;
      rsp_hi    <= rsp_hi_n;
      rsp_zero  <= rsp_zero_n;
      rsp_err   <= rsp_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mcand_n     = mcand;
    lo_q_n      = lo_q;
    alu_op_n    = alu_op;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    rsp_valid_n = rsp_valid;
    rsp_lo_n    = rsp_lo;
    rsp_hi_n    = rsp_hi;
    rsp_zero_n  = rsp_zero;
    rsp_err_n   = rsp_err;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_single_op(req_op)) begin
            alu_op_n = req_op;
            alu_a_n  = req_a;
            alu_b_n  = req_b;
            state_n  = ST_SINGLE;
          end else if (req_op == OP_MULTU) begin
            mcand_n  = req_a;
            lo_q_n   = req_b[XLEN-1:1];
            cnt_n    = '0;
            alu_op_n = OP_ADD;
            alu_a_n  = '0;
            alu_b_n  = req_b[0] ? req_a : '0;
            state_n  = ST_MUL;
          end else begin
            rsp_err_n   = 1'b1;
            rsp_lo_n    = '0;
            rsp_hi_n    = '0;
            rsp_zero_n  = 1'b1;
            rsp_valid_n = 1'b1;
            state_n     = ST_DONE;
          end
        end
      end
      ST_SINGLE: begin
        // Only ADD trusts alu_zero (carry); the SUB zero flag is sticky in the ALU.
        rsp_lo_n    = alu_z;
        rsp_hi_n    = (alu_op == OP_ADD) ? {{(XLEN-1){1'b0}}, alu_zero} : '0;
        rsp_zero_n  = (alu_z == '0);
        rsp_valid_n = 1'b1;
        state_n     = ST_DONE;
      end
      ST_MUL: begin
        lo_q_n  = mul_lo[XLEN-1:1];
        alu_a_n = mul_hi;
        alu_b_n = mul_lo[0] ? mcand : '0;
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(XLEN - 1)) begin
          rsp_hi_n    = mul_hi;
          rsp_lo_n    = mul_lo;
          rsp_zero_n  = (mul_lo == '0);
          rsp_valid_n = 1'b1;
          state_n     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    req_ready_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq with a behavioural ALU (sticky SUB zero flag) and an arithmetic reference model.
module tb_alu_seq;

  localparam logic [3:0] T_AND = 4'b0000, T_OR = 4'b0001, T_ADD = 4'b0010;
  localparam logic [3:0] T_SUB = 4'b0110, T_SLT = 4'b0111, T_MUL = 4'b1000;
  localparam logic [3:0] OPS [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                     4'b0111, 4'b1000, 4'b0011, 4'b1111};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_op, alu_op;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_z, rsp_lo, rsp_hi;
  logic        alu_zero, rsp_zero, rsp_err;
  logic        sticky;
  logic [32:0] alu_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          lat, acc, acc_prev, lat_prev, lat_e;
  logic        rdy, tout, eerr;
  logic [31:0] elo, ehi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // External ALU: ADD reports carry on zero; SUB zero flag sticks once set.
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_z    = '0;
    alu_zero = 1'b0;
    case (alu_op)
      T_AND: alu_z = alu_a & alu_b;
      T_OR:  alu_z = alu_a | alu_b;
      T_ADD: alu_z = alu_sum[31:0];
      T_SUB: alu_z = alu_a - alu_b;
      T_SLT: alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = '0;
    endcase
    if (alu_op == T_ADD) alu_zero = alu_sum[32];
    else alu_zero = (alu_z == '0) || (alu_op == T_SUB && sticky);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky <= 1'b0;
    else if (alu_op == T_SUB && alu_z == '0) sticky <= 1'b1;
  end

  task automatic model(input logic [3:0] op, input logic [31:0] a, b,
                       output logic [31:0] lo, hi, output logic err, output int l);
    logic [32:0] s;
    logic [63:0] p;
    err = 1'b0; hi = '0; lo = '0; l = 2;
    case (op)
      T_AND: lo = a & b;
      T_OR:  lo = a | b;
      T_ADD: begin s = {1'b0, a} + {1'b0, b}; lo = s[31:0]; hi = {31'd0, s[32]}; end
      T_SUB: lo = a - b;
      T_SLT: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      T_MUL: begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32]; l = 33; end
      default: begin err = 1'b1; l = 1; end
    endcase
  endtask

  // Issue one request; returns at the first falling edge where rsp_valid is seen.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b,
                       output int l, output int ac, output logic rdy_seen, output logic to);
    to = 1'b0; rdy_seen = 1'b0; l = 0; ac = 0;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      to = 1'b1; req_valid = 1'b0;
      return;
    end
    ac = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    while (!to) begin
      @(negedge clk);
      l++;
      if (rsp_valid) break;
      if (req_ready) rdy_seen = 1'b1;
      if (l > 100) to = 1'b1;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b vld=%b z=%b e=%b want 1 0 0 0", req_ready, rsp_valid, rsp_zero, rsp_err);
    end
    checks++;
    if ({alu_op, alu_a, alu_b, rsp_hi, rsp_lo} !== 132'd0) begin
      errors++;
      $display("FAIL reset_data got op=%h a=%h b=%h hi=%h lo=%h want all 0", alu_op, alu_a, alu_b, rsp_hi, rsp_lo);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add_carry();
    do_op(T_ADD, 32'hFFFF_FFFF, 32'h1, lat, acc, rdy, tout);
    checks++;
    if (tout || lat != 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++;
    if ({rsp_hi, rsp_lo, rsp_zero, rsp_err} !== {32'h1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_carry got hi=%h lo=%h z=%b e=%b want hi=1 lo=0 z=1 e=0", rsp_hi, rsp_lo, rsp_zero, rsp_err);
    end
    take_rsp();
  endtask

  task automatic test_sub_sticky();
    do_op(T_SUB, 32'd5, 32'd5, lat, acc, rdy, tout);
    checks++;
    if (tout || rsp_lo !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL sub_equal got lo=%h z=%b want lo=0 z=1", rsp_lo, rsp_zero);
    end
    take_rsp();
    do_op(T_SUB, 32'd7, 32'd3, lat, acc, rdy, tout);
    checks++;
    if (tout || {rsp_hi, rsp_lo, rsp_zero} !== {32'd0, 32'd4, 1'b0}) begin
      errors++; $display("FAIL sub_sticky got hi=%h lo=%h z=%b want hi=0 lo=4 z=0", rsp_hi, rsp_lo, rsp_zero);
    end
    take_rsp();
  endtask

  task automatic test_slt();
    do_op(T_SLT, 32'h8000_0000, 32'h1, lat, acc, rdy, tout);
    checks++;
    if (tout || rsp_lo !== 32'd1) begin errors++; $display("FAIL slt_neg got %h want 1", rsp_lo); end
    take_rsp();
    do_op(T_SLT, 32'd3, 32'd2, lat, acc, rdy, tout);
    checks++;
    if (tout || rsp_lo !== 32'd0 || rsp_zero !== 1'b1) begin
      errors++; $display("FAIL slt_pos got lo=%h z=%b want lo=0 z=1", rsp_lo, rsp_zero);
    end
    take_rsp();
  endtask

  task automatic test_multu();
    do_op(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, acc, rdy, tout);
    checks++;
    if (tout || lat != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL mul_ready got ready-high=%b want 0", rdy); end
    checks++;
    if ({rsp_hi, rsp_lo, rsp_zero} !== {32'hFFFF_FFFE, 32'h1, 1'b0}) begin
      errors++; $display("FAIL mul_max got hi=%h lo=%h z=%b want hi=fffffffe lo=1 z=0", rsp_hi, rsp_lo, rsp_zero);
    end
    take_rsp();
    do_op(T_MUL, 32'h1234_5678, 32'd0, lat, acc, rdy, tout);
    checks++;
    if (tout || {rsp_hi, rsp_lo, rsp_zero} !== {64'd0, 1'b1}) begin
      errors++; $display("FAIL mul_zero got hi=%h lo=%h z=%b want 0 0 1", rsp_hi, rsp_lo, rsp_zero);
    end
    take_rsp();
  endtask

  task automatic test_bad_op();
    do_op(4'b0011, 32'hDEAD_BEEF, 32'h1, lat, acc, rdy, tout);
    checks++;
    if (tout || lat != 1 || rsp_err !== 1'b1 || rsp_lo !== 32'd0) begin
      errors++; $display("FAIL bad_op got lat=%0d err=%b lo=%h want lat=1 err=1 lo=0", lat, rsp_err, rsp_lo);
    end
    take_rsp();
    checks++;
    if (rsp_err !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bad_op_clear got err=%b vld=%b rdy=%b want 0 0 1", rsp_err, rsp_valid, req_ready);
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    model(T_ADD, a, b, elo, ehi, eerr, lat_e);
    do_op(T_ADD, a, b, lat, acc, rdy, tout);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_zero, rsp_err} !== {1'b1, 1'b0, ehi, elo, elo == 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d got vld=%b rdy=%b hi=%h lo=%h want vld=1 rdy=0 hi=%h lo=%h", i, rsp_valid, req_ready, rsp_hi, rsp_lo, ehi, elo);
      end
    end
    take_rsp();
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    req_op = T_MUL; req_a = $urandom | 32'h1; req_b = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_mul got rdy=%b vld=%b want 0 0", req_ready, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_err, alu_op, alu_a, alu_b, rsp_hi, rsp_lo} !== {4'b1000, 132'd0}) begin
      errors++;
      $display("FAIL mid_mul_reset got rdy=%b vld=%b op=%h a=%h b=%h hi=%h lo=%h want reset values", req_ready, rsp_valid, alu_op, alu_a, alu_b, rsp_hi, rsp_lo);
    end
    @(negedge clk) rst_n = 1'b1;
    do_op(T_ADD, 32'd2, 32'd3, lat, acc, rdy, tout);
    checks++;
    if (tout || lat != 2 || {rsp_hi, rsp_lo, rsp_err} !== {32'd0, 32'd5, 1'b0}) begin
      errors++; $display("FAIL post_reset_add got lat=%0d hi=%h lo=%h want lat=2 hi=0 lo=5", lat, rsp_hi, rsp_lo);
    end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    rsp_ready = 1'b1;
    lat_prev = 0; acc_prev = 0;
    for (int n = 0; n < 6; n++) begin
      op = OPS[n % 8]; a = $urandom; b = $urandom;
      if (n == 1) op = T_MUL;
      if (n == 3) op = 4'b1111;
      model(op, a, b, elo, ehi, eerr, lat_e);
      do_op(op, a, b, lat, acc, rdy, tout);
      checks++;
      if (tout || {rsp_hi, rsp_lo, rsp_err} !== {ehi, elo, eerr} || lat != lat_e) begin
        errors++; $display("FAIL b2b_result_%0d got lat=%0d hi=%h lo=%h e=%b want lat=%0d hi=%h lo=%h e=%b", n, lat, rsp_hi, rsp_lo, rsp_err, lat_e, ehi, elo, eerr);
      end
      if (n > 0) begin
        checks++;
        if (acc - acc_prev != lat_prev + 1) begin
          errors++; $display("FAIL b2b_spacing_%0d got %0d want %0d", n, acc - acc_prev, lat_prev + 1);
        end
      end
      acc_prev = acc; lat_prev = lat_e;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = OPS[$urandom_range(0, 7)]; a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if (op == T_MUL && $urandom_range(0, 2) == 0) b = 32'd1 << $urandom_range(0, 31);
      model(op, a, b, elo, ehi, eerr, lat_e);
      do_op(op, a, b, lat, acc, rdy, tout);
      checks++;
      if (tout || lat != lat_e) begin
        errors++; $display("FAIL rand_lat_%0d op=%h got %0d want %0d", n, op, lat, lat_e);
      end
      checks++;
      if ({rsp_hi, rsp_lo, rsp_zero, rsp_err} !== {ehi, elo, elo == 32'd0, eerr}) begin
        errors++;
        $display("FAIL rand_res_%0d op=%h a=%h b=%h got hi=%h lo=%h z=%b e=%b want hi=%h lo=%h e=%b", n, op, a, b, rsp_hi, rsp_lo, rsp_zero, rsp_err, ehi, elo, eerr);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_rsp();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_add_carry();
    test_sub_sticky();
    test_slt();
    test_multu();
    test_bad_op();
    test_hold();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
